mod_addsub_pipe: RTL
====================

// Module: mod_addsub_pipe
// PURPOSE
//  Pipelined, elastic modular add/sub unit; generalises the combinational dual-12b Kyber / 24b Dilithium adder.
//  Breaks the add->trial-subtract->select critical path into registered stages with valid/ready flow control.
//  Sits between butterfly multiplier outputs and the NTT/INTT writeback path; one result per cycle sustained.
//  Carries a sideband tag (address/index) alongside each operation.
// PARAMETERS
//  KQ      3329     Kyber modulus, 12-bit lane reduction
//  DQ      8380417  Dilithium modulus, 24-bit reduction
//  STAGES  2        pipeline depth, legal values 1 or 2
//  TAG_W   8        sideband tag width, passed through unchanged
// PORTS
//  clk        in   1      clock
//  rst        in   1      synchronous active-high reset
//  in_valid   in   1      input operation valid
//  in_ready   out  1      unit accepts operation this cycle
//  in_mode    in   1      0 = Kyber dual-lane 12b (mod KQ); 1 = Dilithium single 24b (mod DQ)
//  in_op      in   2      per-lane op: bit1 = hi lane, bit0 = lo lane; 0 = a+b, 1 = a-b (mode 1 uses bit0 only)
//  in_a       in   24     operand A: {hi[23:12], lo[11:0]} or 24b value
//  in_b       in   24     operand B, same packing
//  in_tag     in   TAG_W  sideband tag
//  out_valid  out  1      result valid
//  out_ready  in   1      downstream accepts result
//  out_sum    out  24     {hi, lo} lane results or 24b result
//  out_tag    out  TAG_W  tag of this result
//  out_err    out  1      an operand was not reduced (lane >= KQ or value >= DQ); result still produced
// BEHAVIOUR
//  - Reset (synchronous, active-high): all stage valids cleared; out_valid=0, out_sum=0, out_tag=0, out_err=0;
//    in_ready=1 in the cycle after reset. Operations in flight when rst is asserted are discarded, not completed.
//  - Transfer: input accepted when in_valid && in_ready; output consumed when out_valid && out_ready.
//  - in_ready = !stage1_valid || stage1_advances; no combinational path from in_valid to in_ready.
//  - Latency: STAGES cycles from acceptance to out_valid with out_ready held high; throughput 1/cycle.
//  - Stall: with out_ready=0 and the pipe full, all stages and outputs hold; no result is dropped or duplicated.
//    Bubbles collapse, so a downstream stall does not block an empty stage from filling.
//  - Stage 1 (STAGES=2): raw s = a+b (carry kept) or d = a-b (borrow kept) per lane; trial s-q computed; registered.
//  - Stage 2 / final: add result = (carry || s>=q) ? s-q : s; sub result = borrow ? d+q : d.
//  - STAGES=1: both steps in one registered stage; outputs still registered, never combinational from inputs.
//  - Mode 0: lanes are independent; no carry crosses bit 12; each lane result lies in [0, KQ-1].
//  - Mode 1: the full 24b result lies in [0, DQ-1]; in_op[1] is ignored.
//  - out_err: computed from the accepted operands and travels with them. Unreduced inputs yield a
//    wrapped-but-defined value (the same single conditional correction), never X.
//  - Mode, op and tag are captured per operation; changing them while stalled affects only new operations.
//  - Simultaneous accept and emit on a full pipe is legal and keeps 100% throughput.
// TESTING
//  1. Mode 0, op=00, a={12'd3000,12'd5}, b={12'd1000,12'd3328} -> out_sum={12'd671,12'd4}, err=0, STAGES cycles later.
//  2. Mode 0, op=11, a={12'd5,12'd0}, b={12'd10,12'd1} -> out_sum={12'd3324,12'd3328}.
//  3. Mode 1, op=0, a=8380416, b=1 -> 0; op=1, a=0, b=1 -> 8380416; a=8380417 -> err=1.
//  4. Stream of 16 ops, out_ready toggled 1010/0011 -> all 16 results in order with matching tags, none lost.
//  5. Assert rst with 2 ops in flight -> out_valid=0 next cycle, no stale result appears later, in_ready=1.
//  6. Random 10k ops in both modes vs a golden (a±b) mod q model, STAGES=1 and 2 -> exact match.

Source files
------------

// File: rtl/mod_addsub_pipe.sv
// Elastic modular add/sub unit: dual-lane 12b mod KQ or single 24b mod DQ.
// Raw add/sub plus trial correction, then a select stage, with valid/ready flow control.
module mod_addsub_pipe #(
  parameter int KQ     = 3329,
  parameter int DQ     = 8380417,
  parameter int STAGES = 2,
  parameter int TAG_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [1:0]       in_op,
  input  logic [23:0]      in_a,
  input  logic [23:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [23:0]      out_sum,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  localparam logic [11:0] KQ12 = KQ[11:0];
  localparam logic [23:0] DQ24 = DQ[23:0];

  typedef struct packed {
    logic        f;   // carry (add) or borrow (sub)
    logic [11:0] r;   // raw lane result
    logic        tb;  // borrow of the trial subtraction
    logic [11:0] t;   // trial: r-q for add, r+q for sub
  } lane12_t;

  typedef struct packed {
    logic        f;
    logic [23:0] r;
    logic        tb;
    logic [23:0] t;
  } lane24_t;

  typedef struct packed {
    logic             mode;
    logic [1:0]       op;
    logic [23:0]      raw;
    logic [1:0]       flag;
    logic [23:0]      trial;
    logic [1:0]       tborrow;
    logic             err;
    logic [TAG_W-1:0] tag;
  } stage_t;

  function automatic lane12_t lane12(input logic [11:0] a, input logic [11:0] b,
                                     input logic sub);
    lane12_t    res;
    logic [12:0] raw;
    logic [12:0] trial;
    raw   = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    trial = sub ? ({1'b0, raw[11:0]} + {1'b0, KQ12}) : ({1'b0, raw[11:0]} - {1'b0, KQ12});
    res.f  = raw[12];
    res.r  = raw[11:0];
    res.tb = trial[12];
    res.t  = trial[11:0];
    return res;
  endfunction

  function automatic lane24_t lane24(input logic [23:0] a, input logic [23:0] b,
                                     input logic sub);
    lane24_t    res;
    logic [24:0] raw;
    logic [24:0] trial;
    raw   = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    trial = sub ? ({1'b0, raw[23:0]} + {1'b0, DQ24}) : ({1'b0, raw[23:0]} - {1'b0, DQ24});
    res.f  = raw[24];
    res.r  = raw[23:0];
    res.tb = trial[24];
    res.t  = trial[23:0];
    return res;
  endfunction

  // Single conditional correction: add takes the trial when it overflowed or s >= q,
  // sub takes the trial (d + q) only when the raw difference borrowed.
  function automatic logic [23:0] finish(input stage_t st);
    logic [1:0]  pick;
    logic [23:0] res;
    for (int i = 0; i < 2; i++) begin
      pick[i] = st.op[i] ? st.flag[i] : (st.flag[i] || !st.tborrow[i]);
    end
    if (st.mode) begin
      res = pick[0] ? st.trial : st.raw;
    end else begin
      res = {pick[1] ? st.trial[23:12] : st.raw[23:12],
             pick[0] ? st.trial[11:0]  : st.raw[11:0]};
    end
    return res;
  endfunction

  lane12_t lo_lane;
  lane12_t hi_lane;
  lane24_t wide_lane;
  stage_t  s1_next;
  stage_t  fin;
  logic    fin_valid;
  logic    out_adv;

  assign lo_lane   = lane12(in_a[11:0],  in_b[11:0],  in_op[0]);
  assign hi_lane   = lane12(in_a[23:12], in_b[23:12], in_op[1]);
  assign wide_lane = lane24(in_a, in_b, in_op[0]);
  assign out_adv   = !out_valid || out_ready;

  always_comb begin
    s1_next      = '0;
    s1_next.mode = in_mode;
    s1_next.op   = in_op;
    s1_next.tag  = in_tag;
    if (in_mode) begin
      s1_next.raw     = wide_lane.r;
      s1_next.flag    = {1'b0, wide_lane.f};
      s1_next.trial   = wide_lane.t;
      s1_next.tborrow = {1'b0, wide_lane.tb};
      s1_next.err     = (in_a >= DQ24) || (in_b >= DQ24);
    end else begin
      s1_next.raw     = {hi_lane.r, lo_lane.r};
      s1_next.flag    = {hi_lane.f, lo_lane.f};
      s1_next.trial   = {hi_lane.t, lo_lane.t};
      s1_next.tborrow = {hi_lane.tb, lo_lane.tb};
      s1_next.err     = (in_a[11:0] >= KQ12) || (in_a[23:12] >= KQ12) ||
                        (in_b[11:0] >= KQ12) || (in_b[23:12] >= KQ12);
    end
  end

  generate
    if (STAGES == 2) begin : g_two
      stage_t s1_q;
      logic   s1_valid;

      // Stage 1 may refill whenever it is empty or its content moves on this cycle.
      assign in_ready  = !s1_valid || out_adv;
      assign fin       = s1_q;
      assign fin_valid = s1_valid;

      // NOTE: sequential state uses non-blocking assignments so every register samples
      // pre-edge values; the datapath payload is left unreset because only valid gates it.
      always_ff @(posedge clk) begin
        if (rst) begin
          s1_valid <= 1'b0;
        end else if (in_ready) begin
          s1_valid <= in_valid;
          if (in_valid) s1_q <= s1_next;
        end
      end
    end else begin : g_one
      assign in_ready  = out_adv;
      assign fin       = s1_next;
      assign fin_valid = in_valid;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_tag   <= '0;
      out_err   <= 1'b0;
    end else if (out_adv) begin
      out_valid <= fin_valid;
      if (fin_valid) begin
        out_sum <= finish(fin);
        out_tag <= fin.tag;
        out_err <= fin.err;
      end
    end
  end

endmodule
